hpu_if_ras: RTL
===============

// Module: hpu_if_ras
// PURPOSE
//  Return-address stack consuming the IF1 quick-decode classification (qdec_type_e).
//  - IS_CALL pushes the call's link address (pc+4).
//  - IS_RET pops and supplies the predicted return target to the IF next-pc mux in the same cycle.
//  - Every prediction carries a pointer checkpoint; backend flushes restore it, then replay the flushing inst.
// PARAMETERS
//  RAS_DEPTH  8  entries; power of two, >=2
// PORTS
//  clk_i             in   1             clock
//  rst_i             in   1             synchronous reset, active-high
//  if_vld_i          in   1             IF1 holds a valid instruction
//  if_stall_i        in   1             IF1 stalled; no state update this cycle
//  qdec_type_i       in   qdec_type_e   quick-decode class of IF1 inst
//  cur_inst_pc_i     in   pc_t          pc of IF1 inst
//  ras_pred_vld_o    out  1             ret target valid (IS_RET and stack non-empty)
//  ras_pred_npc_o    out  pc_t          predicted return address (top of stack)
//  ras_ckpt_o        out  ras_ckpt_t    {ptr,cnt} before this inst's update; travels down the pipe
//  flush_i           in   1             backend redirect; overrides IF activity
//  flush_ckpt_i      in   ras_ckpt_t    checkpoint of the flushing instruction
//  flush_type_i      in   qdec_type_e   resolved class of the flushing instruction
//  flush_pc_i        in   pc_t          pc of the flushing instruction
// BEHAVIOUR
//  - Clock and reset: one clock; reset is synchronous and active-high on rst_i.
//  - State: stack[RAS_DEPTH] of pc_t, ptr (log2 DEPTH bits, points at top), cnt (0..DEPTH).
//  - Reset: ptr=0, cnt=0. Stack contents are not reset.
//  - Outputs are combinational from registered state; during and after reset ras_pred_vld_o=0, ras_ckpt_o=0.
//  - Read: ras_pred_npc_o = stack[ptr], always driven.
//    ras_pred_vld_o = if_vld_i & (qdec_type_i==IS_RET) & (cnt!=0) & !flush_i.
//  - Update enable: upd = if_vld_i & !if_stall_i & !flush_i. Effect is visible from the next cycle.
//  - Push (upd & IS_CALL): ptr<=ptr+1 (mod DEPTH); stack[ptr+1]<=cur_inst_pc_i+4; cnt<=min(cnt+1,DEPTH).
//  - Full push: overwrites the oldest entry (circular wrap); cnt stays at DEPTH.
//  - Pop (upd & IS_RET & cnt!=0): ptr<=ptr-1 (mod DEPTH); cnt<=cnt-1.
//  - Empty pop: no change, and ras_pred_vld_o=0, so IF falls back to the sequential/BTB target.
//  - Other types (NORMAL, BRANCH, JAL, JALR): no change.
//  - Flush (priority over upd): start from ptr=flush_ckpt_i.ptr, cnt=flush_ckpt_i.cnt, then apply flush_type_i:
//    - IS_CALL: push flush_pc_i+4 using the push rules above.
//    - IS_RET: pop using the pop rules above.
//    - Otherwise: restore only.
//    - Result is written in one cycle.
//  - Stale-top rule: entries overwritten by wrong-path pushes are not repaired.
//    A flush-IS_CALL re-writes its own slot, so that slot is correct.
//  - Arithmetic: pc+4 wraps at the pc_t width. ptr arithmetic is modulo RAS_DEPTH with natural wrap.
//  - Reset mid-operation: reset wins over flush and upd in the same cycle.
// STRUCTURE
//  - hpu_pkg additions:
//    - RAS_DEPTH default constant
//    - RAS_PTR_W=$clog2(RAS_DEPTH), RAS_CNT_W=$clog2(RAS_DEPTH+1)
//    - typedef struct packed {ptr; cnt} ras_ckpt_t
//  - Single module with no sub-modules. Storage is a flop array (DEPTH is small); one write port per cycle.
//  - One helper function ras_apply(ckpt,type,pc) returns the next {ptr,cnt,wr_en,wr_data}.
//    It is shared by the IF path and the flush path.
// TESTING
//  1) Reset, then IS_RET at pc 0x100 -> ras_pred_vld_o=0, ras_ckpt_o={0,0}, state unchanged.
//  2) CALL pc=0x1000, CALL pc=0x2000, RET, RET:
//     - first RET -> pred 0x2004 valid;
//     - second RET -> pred 0x1004 valid;
//     - third RET -> vld=0, cnt=0.
//  3) 9 CALLs at pcs 0x10..0x90 (DEPTH=8) -> cnt=8, ptr wrapped.
//     9 RETs -> targets 0x94,0x84..0x24 valid; 9th RET -> vld=0.
//  4) CALL with if_stall_i=1 for 3 cycles, then released -> exactly one push; ckpt cnt increments by 1.
//  5) Speculation and recovery:
//     - CALL 0x1000 (ckpt C0), wrong-path CALL 0x3000, RET;
//     - flush with ckpt C0, type IS_CALL, pc 0x1000 -> cnt=1, top=0x1004; next RET predicts 0x1004.
//  6) Flush and IS_CALL upd in the same cycle -> only the flush effect is applied.
//     rst_i asserted together with a flush -> ptr=0, cnt=0.

Source files
------------

// File: rtl/hpu_if_ras_pkg.sv
// Shared types for the IF-stage return-address stack: quick-decode classes,
// pointer checkpoint, and the next-state helper used by both the fetch and flush paths.
package hpu_if_ras_pkg;

  localparam int RAS_DEPTH = 8;
  localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
  localparam int RAS_CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PC_W      = 32;

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic [2:0] {
    NORMAL,
    BRANCH,
    JAL,
    JALR,
    IS_CALL,
    IS_RET
  } qdec_type_e;

  typedef struct packed {
    logic [RAS_PTR_W-1:0] ptr;
    logic [RAS_CNT_W-1:0] cnt;
  } ras_ckpt_t;

  typedef struct packed {
    ras_ckpt_t ckpt;
    logic      wr_en;
    pc_t       wr_data;
  } ras_next_t;

  localparam logic [RAS_CNT_W-1:0] RAS_CNT_MAX = RAS_CNT_W'(RAS_DEPTH);

  // A push always lands in the slot the new ptr points at, so no separate write address.
  function automatic ras_next_t ras_apply(input ras_ckpt_t ckpt, input qdec_type_e qtype,
                                          input pc_t pc);
    ras_next_t nxt;
    nxt.ckpt    = ckpt;
    nxt.wr_en   = 1'b0;
    nxt.wr_data = pc + PC_W'(4);
    case (qtype)
      IS_CALL: begin
        nxt.ckpt.ptr = ckpt.ptr + RAS_PTR_W'(1);
        nxt.wr_en    = 1'b1;
        if (ckpt.cnt != RAS_CNT_MAX) nxt.ckpt.cnt = ckpt.cnt + RAS_CNT_W'(1);
      end
      IS_RET: begin
        if (ckpt.cnt != '0) begin
          nxt.ckpt.ptr = ckpt.ptr - RAS_PTR_W'(1);
          nxt.ckpt.cnt = ckpt.cnt - RAS_CNT_W'(1);
        end
      end
      default: ;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/hpu_if_ras.sv
// Return-address stack fed by IF1 quick-decode: pushes link addresses on calls,
// predicts return targets on rets, and restores from a pipe checkpoint on backend flush.
module hpu_if_ras
  import hpu_if_ras_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       if_vld_i,
  input  logic       if_stall_i,
  input  qdec_type_e qdec_type_i,
  input  pc_t        cur_inst_pc_i,
  output logic       ras_pred_vld_o,
  output pc_t        ras_pred_npc_o,
  output ras_ckpt_t  ras_ckpt_o,
  input  logic       flush_i,
  input  ras_ckpt_t  flush_ckpt_i,
  input  qdec_type_e flush_type_i,
  input  pc_t        flush_pc_i
);

  pc_t       stack_q [RAS_DEPTH];
  ras_ckpt_t ckpt_q;
  ras_next_t nxt_d;
  logic      upd;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    upd   = if_vld_i & ~if_stall_i & ~flush_i;
    nxt_d = '{ckpt: ckpt_q, wr_en: 1'b0, wr_data: '0};
    if (flush_i)  nxt_d = ras_apply(flush_ckpt_i, flush_type_i, flush_pc_i);
    else if (upd) nxt_d = ras_apply(ckpt_q, qdec_type_i, cur_inst_pc_i);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) ckpt_q <= '0;
    else       ckpt_q <= nxt_d.ckpt;
  end

  // NOTE: the stack array is deliberately not reset; cnt alone says which entries are live.
  always_ff @(posedge clk_i) begin
    if (!rst_i && nxt_d.wr_en) stack_q[nxt_d.ckpt.ptr] <= nxt_d.wr_data;
  end

  // Outputs are forced quiet while reset is held, before ckpt_q has been cleared.
  assign ras_pred_npc_o = stack_q[ckpt_q.ptr];
  assign ras_pred_vld_o = ~rst_i & if_vld_i & (qdec_type_i == IS_RET)
                        & (ckpt_q.cnt != '0) & ~flush_i;
  assign ras_ckpt_o     = rst_i ? '0 : ckpt_q;

endmodule
